bifrost_irqc: RTL and testbench

//   Parametrised interrupt controller for the 6502 bus: replaces fixed AND-ing of active-low IRQ lines.

---
 rtl/bifrost_irqc.sv | 103 ++++++++++
 tb/tb_bifrost_irqc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bifrost_irqc.sv
// bifrost_irqc: interrupt controller for the 6502 bus.
// Syncs inputs, latches pending per mode, drives registered irq_n.
module bifrost_irqc #(
  parameter int CHANNELS = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW = {CHANNELS{1'b1}}
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cs_n,
  input  logic                rw,
  input  logic [2:0]          addr,
  input  logic                wr_stb,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_out_en,
  input  logic [CHANNELS-1:0] irq_in,
  output logic                irq_n,
  output logic [CHANNELS-1:0] irq_active
);

  typedef logic [CHANNELS-1:0] ch_t;

  ch_t sync_q [SYNC_STAGES];
  ch_t s;
  ch_t prev;
  ch_t pending;
  ch_t enable;
  ch_t mode;
  ch_t pend_nxt;
  ch_t clr;
  ch_t frc;
  ch_t act;
  ch_t wdat;
  logic wr;
  logic [7:0] vector;

  // Chain resets to the idle input level so nothing looks asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++)
        sync_q[k] <= ACTIVE_LOW;
    end else begin
      sync_q[0] <= irq_in;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign wr   = wr_stb & ~cs_n & ~rw;
  assign wdat = data_in[CHANNELS-1:0];
  assign clr  = (wr && addr == 3'd1) ? wdat : '0;
  assign frc  = (wr && addr == 3'd5) ? wdat : '0;
  assign act  = pending & enable;

  // Edge channels: set terms dominate the W1C clear.
  assign pend_nxt = (~mode & s)
                  | (mode & ((s & ~prev) | frc
                  | (pending & ~clr)));

  always_ff @(posedge clock) begin
    if (reset) begin
      prev       <= '0;
      pending    <= '0;
      enable     <= '0;
      mode       <= '0;
      irq_active <= '0;
      irq_n      <= 1'b1;
    end else begin
      prev       <= s;
      pending    <= pend_nxt;
      irq_active <= act;
      irq_n      <= ~|act;
      if (wr && addr == 3'd2)
        enable <= wdat;
      if (wr && addr == 3'd3)
        mode <= wdat;
    end
  end

  always_comb begin
    vector = 8'h00;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (act[i])
        vector = {1'b1, 4'b0000, 3'(i)};
  end

  always_comb begin
    data_out = 8'h00;
    case (addr)
      3'd0:    data_out = 8'(s);
      3'd1:    data_out = 8'(pending);
      3'd2:    data_out = 8'(enable);
      3'd3:    data_out = 8'(mode);
      3'd4:    data_out = vector;
      default: data_out = 8'h00;
    endcase
  end

  assign data_out_en = ~cs_n & rw;

endmodule

// File: tb/tb_bifrost_irqc.sv
// tb_bifrost_irqc: directed checks of bifrost_irqc.
// Default parameters: 8 channels, 2 sync stages, all active low.
module tb_bifrost_irqc;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       rw;
  logic [2:0] addr;
  logic       wr_stb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [7:0] irq_in;
  logic       irq_n;
  logic [7:0] irq_active;

  int checks = 0;
  int failures = 0;
  logic [7:0] d;

  bifrost_irqc dut (
    .clock(clock),
    .reset(reset),
    .cs_n(cs_n),
    .rw(rw),
    .addr(addr),
    .wr_stb(wr_stb),
    .data_in(data_in),
    .data_out(data_out),
    .data_out_en(data_out_en),
    .irq_in(irq_in),
    .irq_n(irq_n),
    .irq_active(irq_active)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    cs_n = 1'b0; rw = 1'b0; addr = a; data_in = v; wr_stb = 1'b1;
    tick();
    cs_n = 1'b1; rw = 1'b1; wr_stb = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    addr = a; cs_n = 1'b0; rw = 1'b1;
    #1;
    v = data_out;
    cs_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = 8'hFF;
    tick();
    reset = 1'b0;
    checks++;
    if (irq_n !== 1'b1) begin
      failures++; $display("FAIL reset_irq_n got %b exp 1", irq_n);
    end
    checks++;
    if (irq_active !== 8'h00) begin
      failures++; $display("FAIL reset_active got %h exp 00", irq_active);
    end
    for (int r = 0; r < 6; r++) begin
      rd(3'(r), d);
      checks++;
      if (d !== 8'h00) begin
        failures++; $display("FAIL reset_reg%0d got %h exp 00", r, d);
      end
    end
    cs_n = 1'b0; rw = 1'b1;
    #1;
    checks++;
    if (data_out_en !== 1'b1) begin
      failures++; $display("FAIL data_out_en got %b exp 1", data_out_en);
    end
    cs_n = 1'b1;
  endtask

  task automatic test_level();
    wr(3'd2, 8'h01);
    irq_in[0] = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (irq_n !== 1'b1) begin
      failures++; $display("FAIL level_early got %b exp 1", irq_n);
    end
    tick();
    checks++;
    if (irq_n !== 1'b0) begin
      failures++; $display("FAIL level_assert got %b exp 0", irq_n);
    end
    checks++;
    if (irq_active !== 8'h01) begin
      failures++; $display("FAIL level_active got %h exp 01", irq_active);
    end
    wr(3'd1, 8'h01);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h01) begin
      failures++; $display("FAIL level_w1c got %h exp 01", d);
    end
    irq_in[0] = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (irq_n !== 1'b0) begin
      failures++; $display("FAIL level_release_early got %b exp 0", irq_n);
    end
    tick();
    checks++;
    if (irq_n !== 1'b1) begin
      failures++; $display("FAIL level_release got %b exp 1", irq_n);
    end
  endtask

  task automatic test_edge();
    wr(3'd3, 8'h04);
    wr(3'd2, 8'h04);
    irq_in[2] = 1'b0;
    tick();
    irq_in[2] = 1'b1;
    tick();
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL edge_early got %h exp 00", d);
    end
    tick(); tick(); tick(); tick();
    rd(3'd1, d);
    checks++;
    if (d !== 8'h04) begin
      failures++; $display("FAIL edge_latched got %h exp 04", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 8'h82) begin
      failures++; $display("FAIL edge_vector got %h exp 82", d);
    end
    checks++;
    if (irq_n !== 1'b0) begin
      failures++; $display("FAIL edge_irq_n got %b exp 0", irq_n);
    end
    wr(3'd1, 8'h04);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL edge_w1c got %h exp 00", d);
    end
    checks++;
    if (irq_n !== 1'b0) begin
      failures++; $display("FAIL edge_irq_hold got %b exp 0", irq_n);
    end
    tick();
    checks++;
    if (irq_n !== 1'b1) begin
      failures++; $display("FAIL edge_irq_clear got %b exp 1", irq_n);
    end
  endtask

  task automatic test_priority();
    wr(3'd3, 8'h28);
    irq_in = 8'hD7;
    tick();
    irq_in = 8'hFF;
    tick(); tick();
    wr(3'd2, 8'hFF);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h28) begin
      failures++; $display("FAIL prio_pending got %h exp 28", d);
    end
    rd(3'd4, d);
    checks++;
    if (d !== 8'h83) begin
      failures++; $display("FAIL prio_vec_all got %h exp 83", d);
    end
    wr(3'd2, 8'hF7);
    rd(3'd4, d);
    checks++;
    if (d !== 8'h85) begin
      failures++; $display("FAIL prio_vec_mask got %h exp 85", d);
    end
    wr(3'd1, 8'h28);
    rd(3'd4, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL prio_vec_none got %h exp 00", d);
    end
  endtask

  task automatic test_collision();
    wr(3'd3, 8'h2A);
    irq_in[1] = 1'b0;
    tick();
    irq_in[1] = 1'b1;
    tick(); tick();
    rd(3'd1, d);
    checks++;
    if (d !== 8'h02) begin
      failures++; $display("FAIL coll_first got %h exp 02", d);
    end
    irq_in[1] = 1'b0;
    tick();
    irq_in[1] = 1'b1;
    tick();
    wr(3'd1, 8'h02);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h02) begin
      failures++; $display("FAIL coll_set_wins got %h exp 02", d);
    end
    wr(3'd1, 8'h02);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL coll_plain_w1c got %h exp 00", d);
    end
    wr(3'd5, 8'h01);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL force_level got %h exp 00", d);
    end
    wr(3'd5, 8'h08);
    rd(3'd1, d);
    checks++;
    if (d !== 8'h08) begin
      failures++; $display("FAIL force_edge got %h exp 08", d);
    end
    rd(3'd5, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL force_read got %h exp 00", d);
    end
    wr(3'd1, 8'h08);
  endtask

  task automatic test_write_qual();
    cs_n = 1'b1; rw = 1'b0; addr = 3'd2; data_in = 8'h00; wr_stb = 1'b1;
    tick();
    cs_n = 1'b0; rw = 1'b1;
    tick();
    cs_n = 1'b1; wr_stb = 1'b0;
    rd(3'd2, d);
    checks++;
    if (d !== 8'hF7) begin
      failures++; $display("FAIL write_qual got %h exp f7", d);
    end
  endtask

  task automatic test_reset_mid();
    wr(3'd2, 8'hFF);
    wr(3'd3, 8'h00);
    irq_in = 8'h00;
    tick(); tick(); tick(); tick();
    rd(3'd1, d);
    checks++;
    if (d !== 8'hFF || irq_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_setup got pend=%h irq_n=%b exp ff/0", d, irq_n);
    end
    reset = 1'b1;
    cs_n = 1'b0; rw = 1'b0; addr = 3'd2; data_in = 8'hFF; wr_stb = 1'b1;
    tick();
    reset = 1'b0;
    cs_n = 1'b1; rw = 1'b1; wr_stb = 1'b0;
    checks++;
    if (irq_n !== 1'b1) begin
      failures++; $display("FAIL mid_irq_n got %b exp 1", irq_n);
    end
    rd(3'd2, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL mid_reset_wins got %h exp 00", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL mid_pend_clr got %h exp 00", d);
    end
    tick(); tick();
    rd(3'd0, d);
    checks++;
    if (d !== 8'hFF) begin
      failures++; $display("FAIL mid_status got %h exp ff", d);
    end
    rd(3'd1, d);
    checks++;
    if (d !== 8'h00) begin
      failures++; $display("FAIL mid_repend_early got %h exp 00", d);
    end
    tick();
    rd(3'd1, d);
    checks++;
    if (d !== 8'hFF) begin
      failures++; $display("FAIL mid_repend got %h exp ff", d);
    end
    irq_in = 8'hFF;
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; rw = 1'b1; addr = 3'd0;
    wr_stb = 1'b0; data_in = 8'h00; irq_in = 8'hFF;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_collision();
    test_write_qual();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
